cisr_row_decoder: RTL

Parametrised CISR row-index decoder. It sits between the row-length receiver, the value/index receiver and the multiply array. It keeps one row-length FIFO and one current-row counter per channel. It assigns row IDs dynamically as each channel exhausts its row, skips zero-length rows, and emits one registered beat per accepted value/index beat, tagging each channel with its row ID and an active mask. Inputs are pulse-qualified with no backpressure, so overflow and starvation are flagged rather than stalled.

---
 rtl/cisr_row_decoder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cisr_row_decoder.sv
// ----------------------------------------------------------------------------
// cisr_row_decoder
//
// CISR row-index decoder. It sits between the row-length receiver, the
// value/index receiver and the multiply array. Each channel has a small
// row-length FIFO and a current-row counter. When a channel's counter runs
// out, the channel loads the next length from its FIFO and receives the next
// free row ID. For every accepted value/index beat the block emits one
// registered beat. That beat tags each lane with the row it belongs to and
// says whether the lane carries a real nonzero.
//
// The inputs are pulse-qualified and cannot be back-pressured. A FIFO
// overflow or a beat that arrives while a lane has no row to assign is
// therefore recorded in a sticky flag and the data is discarded.
//
// Optional feature (macro CISR_ROW_DEC_STATS_EN):
//   rows_issued  running total of row IDs handed out (kept across restarts)
//   beats_out    wrapping count of out_rdy pulses
//
// Ports:
//   clk                    clock
//   rst_l                  asynchronous active-low reset
//   row_len_in             one row length per channel
//   row_len_rdy            single-cycle qualifier for row_len_in
//   row_len_done           pulse: no more row lengths for this matrix
//   val_in, col_in         value / column index per lane
//   val_ind_rdy            single-cycle qualifier for val_in / col_in
//   values, col_id         registered copy of the accepted beat
//   row_id                 row owning each lane's element (0 when inactive)
//   lane_active            lane carries a real nonzero
//   out_rdy                single-cycle output qualifier
//   all_done               level: matrix fully consumed
//   row_len_fifo_overflow  sticky: a row-length beat was dropped
//   val_ind_drop           sticky: a value/index beat was dropped
// ----------------------------------------------------------------------------
module cisr_row_decoder #(
    parameter int NUM_CHANNELS       = 4,
    parameter int WORD_W             = 32,
    parameter int ROW_ID_W           = 32,
    parameter int ROW_LEN_FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  row_len_in,
    input  logic                                 row_len_rdy,
    input  logic                                 row_len_done,
    input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  val_in,
    input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  col_in,
    input  logic                                 val_ind_rdy,
    output logic [NUM_CHANNELS-1:0][WORD_W-1:0]  values,
    output logic [NUM_CHANNELS-1:0][WORD_W-1:0]  col_id,
    output logic [NUM_CHANNELS-1:0][ROW_ID_W-1:0] row_id,
    output logic [NUM_CHANNELS-1:0]              lane_active,
    output logic                                 out_rdy,
    output logic                                 all_done,
    output logic                                 row_len_fifo_overflow,
    output logic                                 val_ind_drop
`ifdef CISR_ROW_DEC_STATS_EN
    ,
    output logic [ROW_ID_W-1:0]                  rows_issued,
    output logic [31:0]                          beats_out
`endif
);

    localparam int AW = $clog2(ROW_LEN_FIFO_DEPTH);
    localparam int FW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]                      fifo_mem [NUM_CHANNELS][ROW_LEN_FIFO_DEPTH];
    logic [NUM_CHANNELS-1:0][AW-1:0]        rd_ptr;
    logic [NUM_CHANNELS-1:0][AW-1:0]        wr_ptr;
    logic [NUM_CHANNELS-1:0][FW-1:0]        fill;
    logic [NUM_CHANNELS-1:0][WORD_W-1:0]    cur_len;
    logic [NUM_CHANNELS-1:0][ROW_ID_W-1:0]  cur_row;
    logic [ROW_ID_W-1:0]                    next_row_id;
    logic                                   done_seen;
    logic [1:0]                             state;

    // ------------------------------------------------------------------
    // Per-channel decode
    // ------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0]                fifo_empty;
    logic [NUM_CHANNELS-1:0]                loading;
    logic [NUM_CHANNELS-1:0]                starved;
    logic [NUM_CHANNELS-1:0]                finished;
    logic [NUM_CHANNELS-1:0]                full_after_pop;
    logic [NUM_CHANNELS-1:0][WORD_W-1:0]    head;
    logic [NUM_CHANNELS-1:0][WORD_W-1:0]    eff_len;
    logic [NUM_CHANNELS-1:0][ROW_ID_W-1:0]  eff_row;
    logic [NUM_CHANNELS-1:0][FW-1:0]        fill_after_pop;
    logic [ROW_ID_W-1:0]                    id_acc;

    always_comb begin
        // NOTE: id_acc is a running sum across the lane loop, so it must be a
        // blocking assignment; every output of this block gets a value on
        // every pass so no latch is inferred.
        id_acc = next_row_id;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            fifo_empty[c]     = (fill[c] == '0);
            head[c]           = fifo_mem[c][rd_ptr[c]];
            loading[c]        = (cur_len[c] == '0) && !fifo_empty[c];
            // Lanes loading in the same cycle take IDs in ascending lane order.
            eff_row[c]        = loading[c] ? id_acc : cur_row[c];
            if (loading[c]) begin
                id_acc = id_acc + ROW_ID_W'(1);
            end
            eff_len[c]        = loading[c] ? head[c] : cur_len[c];
            // A zero-length load still leaves the lane without an element.
            starved[c]        = (cur_len[c] == '0) && (!fifo_empty[c] || !done_seen)
                                && !(loading[c] && (head[c] != '0));
            finished[c]       = (cur_len[c] == '0) && fifo_empty[c] && done_seen;
            // The pop is taken into account before the full check, so a full
            // FIFO that is being drained this cycle still accepts a push.
            fill_after_pop[c] = fill[c] - FW'(loading[c]);
            full_after_pop[c] = (fill_after_pop[c] == FW'(ROW_LEN_FIFO_DEPTH));
        end
    end

    logic accept;
    logic push_ok;

    assign accept  = val_ind_rdy && ((state == ST_RUN) || (state == ST_DRAIN)) && !(|starved);
    assign push_ok = row_len_rdy && !(|full_after_pop);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [1:0]          state_n;
    logic                done_seen_n;
    logic [ROW_ID_W-1:0] next_row_id_n;

    always_comb begin
        state_n       = state;
        done_seen_n   = done_seen;
        next_row_id_n = id_acc;
        case (state)
            ST_IDLE:  if (row_len_rdy) state_n = ST_RUN;
            ST_RUN:   if (row_len_done) begin
                          state_n     = ST_DRAIN;
                          done_seen_n = 1'b1;
                      end
            ST_DRAIN: if (&finished) state_n = ST_DONE;
            ST_DONE:  if (row_len_rdy) begin
                          // New matrix: row numbering restarts, flags are kept.
                          state_n       = ST_RUN;
                          done_seen_n   = 1'b0;
                          next_row_id_n = '0;
                      end
            default:  state_n = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Row-length FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers and fill counts are
    // reset, so stale entries are never read.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (push_ok) begin
                fifo_mem[c][wr_ptr[c]] <= row_len_in[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state                 <= ST_IDLE;
            done_seen             <= 1'b0;
            next_row_id           <= '0;
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            fill                  <= '0;
            cur_len               <= '0;
            cur_row               <= '0;
            values                <= '0;
            col_id                <= '0;
            row_id                <= '0;
            lane_active           <= '0;
            out_rdy               <= 1'b0;
            all_done              <= 1'b0;
            row_len_fifo_overflow <= 1'b0;
            val_ind_drop          <= 1'b0;
        end else begin
            state       <= state_n;
            done_seen   <= done_seen_n;
            next_row_id <= next_row_id_n;
            all_done    <= (state_n == ST_DONE);
            out_rdy     <= accept;

            if (row_len_rdy && !push_ok) row_len_fifo_overflow <= 1'b1;
            if (val_ind_rdy && !accept)  val_ind_drop          <= 1'b1;

            if (accept) begin
                values <= val_in;
                col_id <= col_in;
            end

            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (loading[c]) rd_ptr[c] <= rd_ptr[c] + AW'(1);
                if (push_ok)    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                fill[c]    <= fill_after_pop[c] + FW'(push_ok);
                cur_row[c] <= eff_row[c];
                if (accept && (eff_len[c] != '0)) begin
                    cur_len[c] <= eff_len[c] - WORD_W'(1);
                end else begin
                    cur_len[c] <= eff_len[c];
                end
                if (accept) begin
                    // An inactive lane in an accepted beat is always a
                    // finished channel, which reports row 0.
                    lane_active[c] <= (eff_len[c] != '0);
                    row_id[c]      <= (eff_len[c] != '0) ? eff_row[c] : '0;
                end
            end
        end
    end

`ifdef CISR_ROW_DEC_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rows_issued <= '0;
            beats_out   <= '0;
        end else begin
            // id_acc - next_row_id is the number of rows loaded this cycle.
            rows_issued <= rows_issued + (id_acc - next_row_id);
            if (accept) beats_out <= beats_out + 32'd1;
        end
    end
`endif

endmodule
